tdc_meas_ctrl: RTL and testbench



---
 rtl/tdc_meas_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl
//   Measurement sequencer for a single-channel, uncalibrated TDC. Sequences
//   enable/arm/ready, counts coarse clock cycles between start and stop hits,
//   detects timeouts and computes a linear interval:
//     result_ps = coarse * CLOCK_PERIOD_PS + (start_fine - stop_fine) * TAP_PS
//   with negative intervals clamped to 0.
//
//   Optional feature macro: TDC_MEAS_STATS_EN
//     defined   -> meas_count / timeout_count are saturating event counters
//     undefined -> both outputs tied to 0, no counter logic
//
// Ports
//   sys_clk_p       system clock, rising edge
//   sys_rst_n       asynchronous active-low reset
//   tdc_enable      level; low forces idle and clears error / data-valid
//   tdc_arm         acts on rising edge only
//   start_hit       one-cycle start pulse, start_fine valid with it
//   stop_hit        one-cycle stop pulse, stop_fine valid with it
//   result_valid    one-cycle pulse on entry to DONE
//   result_coarse   coarse cycles between start and stop
//   result_ps       unsigned interval in ps
//   led_*           status outputs
//   meas_count      completed measurements (stats build only)
//   timeout_count   timeouts (stats build only)

module tdc_meas_ctrl #(
  parameter int unsigned CLOCK_PERIOD_PS    = 10000,
  parameter int unsigned DELAY_LINE_TAPS    = 256,
  parameter int unsigned TAP_PS             = CLOCK_PERIOD_PS / DELAY_LINE_TAPS,
  parameter int unsigned TIMEOUT_CYCLES     = 100000,
  parameter int unsigned READY_DELAY_CYCLES = 16,
  parameter int unsigned COARSE_W           = 20
) (
  input  logic                sys_clk_p,
  input  logic                sys_rst_n,
  input  logic                tdc_enable,
  input  logic                tdc_arm,
  input  logic                start_hit,
  input  logic [7:0]          start_fine,
  input  logic                stop_hit,
  input  logic [7:0]          stop_fine,
  output logic                result_valid,
  output logic [COARSE_W-1:0] result_coarse,
  output logic [31:0]         result_ps,
  output logic                led_tdc_ready,
  output logic                led_measuring,
  output logic                led_data_valid,
  output logic                led_error,
  output logic [15:0]         meas_count,
  output logic [7:0]          timeout_count
);

  localparam int unsigned InitW = (READY_DELAY_CYCLES > 1) ? $clog2(READY_DELAY_CYCLES) : 1;
  localparam logic [InitW-1:0]    InitLast   = InitW'(READY_DELAY_CYCLES - 1);
  localparam logic [COARSE_W-1:0] CoarseLast = COARSE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [33:0]         PeriodPs   = 34'(CLOCK_PERIOD_PS);
  localparam logic [33:0]         TapPs      = 34'(TAP_PS);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StArmed,
    StMeas,
    StCalc,
    StDone,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic [InitW-1:0]    init_cnt_q, init_cnt_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [7:0]          start_fine_q, start_fine_d;
  logic [7:0]          stop_fine_q, stop_fine_d;
  logic [31:0]         result_ps_q, result_ps_d;
  logic [COARSE_W-1:0] result_coarse_q, result_coarse_d;
  logic                result_valid_q, result_valid_d;
  logic                arm_q;
  logic                arm_rise;

  assign arm_rise = tdc_arm & ~arm_q;

  // Interval arithmetic in 34-bit two's complement. Coarse is bounded by
  // TIMEOUT_CYCLES, so the positive product stays well inside the signed range.
  logic [8:0]  fine_diff;
  logic [33:0] coarse_ps;
  logic [33:0] fine_ps;
  logic [33:0] interval;
  logic [31:0] interval_clamped;

  assign fine_diff = {1'b0, start_fine_q} - {1'b0, stop_fine_q};
  assign coarse_ps = 34'(coarse_q) * PeriodPs;
  assign fine_ps   = {{25{fine_diff[8]}}, fine_diff} * TapPs;
  assign interval  = coarse_ps + fine_ps;

  always_comb begin
    interval_clamped = interval[31:0];
    if (interval[33]) begin
      interval_clamped = '0;
    end else if (interval[32]) begin
      interval_clamped = '1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d         = state_q;
    init_cnt_d      = init_cnt_q;
    coarse_d        = coarse_q;
    start_fine_d    = start_fine_q;
    stop_fine_d     = stop_fine_q;
    result_ps_d     = result_ps_q;
    result_coarse_d = result_coarse_q;
    result_valid_d  = 1'b0;

    unique case (state_q)
      StInit: begin
        if (init_cnt_q == InitLast) begin
          state_d = StIdle;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (tdc_enable && arm_rise) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        // A lone stop_hit is ignored; start and stop together go straight to CALC.
        if (start_hit) begin
          start_fine_d = start_fine;
          coarse_d     = '0;
          if (stop_hit) begin
            stop_fine_d = stop_fine;
            state_d     = StCalc;
          end else begin
            state_d = StMeas;
          end
        end
      end
      StMeas: begin
        // Incrementing on the stop edge too makes coarse equal the edge count
        // from the start edge to the stop edge.
        coarse_d = coarse_q + 1'b1;
        if (stop_hit) begin
          stop_fine_d = stop_fine;
          state_d     = StCalc;
        end else if (coarse_q == CoarseLast) begin
          state_d = StError;
        end
      end
      StCalc: begin
        result_ps_d     = interval_clamped;
        result_coarse_d = coarse_q;
        result_valid_d  = 1'b1;
        state_d         = StDone;
      end
      StDone: begin
        if (arm_rise) begin
          state_d = StArmed;
        end
      end
      StError: begin
        // Only tdc_enable low leaves ERROR.
      end
      default: begin
        state_d = StInit;
      end
    endcase

    // Enable low aborts everything outside INIT; last results are kept.
    if ((state_q != StInit) && !tdc_enable) begin
      state_d         = StIdle;
      result_ps_d     = result_ps_q;
      result_coarse_d = result_coarse_q;
      result_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_p or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q         <= StInit;
      init_cnt_q      <= '0;
      coarse_q        <= '0;
      start_fine_q    <= '0;
      stop_fine_q     <= '0;
      result_ps_q     <= '0;
      result_coarse_q <= '0;
      result_valid_q  <= 1'b0;
      arm_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      coarse_q        <= coarse_d;
      start_fine_q    <= start_fine_d;
      stop_fine_q     <= stop_fine_d;
      result_ps_q     <= result_ps_d;
      result_coarse_q <= result_coarse_d;
      result_valid_q  <= result_valid_d;
      arm_q           <= tdc_arm;
    end
  end

  assign result_valid   = result_valid_q;
  assign result_ps      = result_ps_q;
  assign result_coarse  = result_coarse_q;
  assign led_tdc_ready  = (state_q != StInit);
  assign led_measuring  = (state_q == StArmed) || (state_q == StMeas);
  assign led_data_valid = (state_q == StDone);
  assign led_error      = (state_q == StError);

`ifdef TDC_MEAS_STATS_EN
  logic [15:0] meas_count_q;
  logic [7:0]  timeout_count_q;
  logic        error_entry;

  assign error_entry = (state_q == StMeas) && (state_d == StError);

  always_ff @(posedge sys_clk_p or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meas_count_q    <= '0;
      timeout_count_q <= '0;
    end else begin
      if (result_valid_d && (meas_count_q != 16'hFFFF)) begin
        meas_count_q <= meas_count_q + 1'b1;
      end
      if (error_entry && (timeout_count_q != 8'hFF)) begin
        timeout_count_q <= timeout_count_q + 1'b1;
      end
    end
  end

  assign meas_count    = meas_count_q;
  assign timeout_count = timeout_count_q;
`else
  assign meas_count    = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed self-checking bench for tdc_meas_ctrl. The timeout is shortened to
// 1000 cycles to keep the run short; all other parameters are the defaults.
module tb_tdc_meas_ctrl;

  localparam int unsigned TimeoutCycles = 1000;
  localparam int unsigned CoarseW       = 20;

`ifdef TDC_MEAS_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic               sys_clk_p;
  logic               sys_rst_n;
  logic               tdc_enable;
  logic               tdc_arm;
  logic               start_hit;
  logic [7:0]         start_fine;
  logic               stop_hit;
  logic [7:0]         stop_fine;
  logic               result_valid;
  logic [CoarseW-1:0] result_coarse;
  logic [31:0]        result_ps;
  logic               led_tdc_ready;
  logic               led_measuring;
  logic               led_data_valid;
  logic               led_error;
  logic [15:0]        meas_count;
  logic [7:0]         timeout_count;

  int n_checks = 0;
  int n_fails  = 0;

  tdc_meas_ctrl #(
    .TIMEOUT_CYCLES (TimeoutCycles),
    .COARSE_W       (CoarseW)
  ) u_dut (
    .sys_clk_p      (sys_clk_p),
    .sys_rst_n      (sys_rst_n),
    .tdc_enable     (tdc_enable),
    .tdc_arm        (tdc_arm),
    .start_hit      (start_hit),
    .start_fine     (start_fine),
    .stop_hit       (stop_hit),
    .stop_fine      (stop_fine),
    .result_valid   (result_valid),
    .result_coarse  (result_coarse),
    .result_ps      (result_ps),
    .led_tdc_ready  (led_tdc_ready),
    .led_measuring  (led_measuring),
    .led_data_valid (led_data_valid),
    .led_error      (led_error),
    .meas_count     (meas_count),
    .timeout_count  (timeout_count)
  );

  initial sys_clk_p = 1'b0;
  always #5 sys_clk_p = ~sys_clk_p;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge sys_clk_p);
  endtask

  task automatic do_arm();
    tdc_arm = 1'b1;
    step();
    tdc_arm = 1'b0;
  endtask

  function automatic logic [63:0] stat(input int n);
    return StatsEn ? 64'(n) : 64'd0;
  endfunction

  initial begin
    int ready_at;
    sys_rst_n  = 1'b1;
    tdc_enable = 1'b0;
    tdc_arm    = 1'b0;
    start_hit  = 1'b0;
    start_fine = 8'd0;
    stop_hit   = 1'b0;
    stop_fine  = 8'd0;
    #2 sys_rst_n = 1'b0;
    step();
    step();

    // Reset values
    check_eq("rst_ready", led_tdc_ready, 0);
    check_eq("rst_valid", result_valid, 0);
    check_eq("rst_ps", result_ps, 0);
    check_eq("rst_coarse", result_coarse, 0);
    check_eq("rst_leds", {led_measuring, led_data_valid, led_error}, 0);
    check_eq("rst_counts", {meas_count, timeout_count}, 0);

    // Ready delay: count edges after release until ready rises
    sys_rst_n = 1'b1;
    ready_at  = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (led_tdc_ready && ready_at == 0) ready_at = i;
    end
    check_eq("ready_delay", 64'(ready_at), 16);

    // Basic measurement: 25 cycles, fine 200 -> 100
    tdc_enable = 1'b1;
    step();
    do_arm();
    check_eq("armed_led", led_measuring, 1);
    start_hit = 1'b1; start_fine = 8'd200;
    step();
    start_hit = 1'b0;
    check_eq("meas_led", led_measuring, 1);
    repeat (24) step();
    stop_hit = 1'b1; stop_fine = 8'd100;
    step();
    stop_hit = 1'b0;
    check_eq("calc_no_valid", result_valid, 0);
    step();
    check_eq("basic_valid", result_valid, 1);
    check_eq("basic_coarse", result_coarse, 25);
    check_eq("basic_ps", result_ps, 253900);
    check_eq("basic_dv", led_data_valid, 1);
    check_eq("basic_meas_led", led_measuring, 0);
    step();
    check_eq("basic_valid_pulse", result_valid, 0);
    check_eq("basic_dv_hold", led_data_valid, 1);
    repeat (3) step();
    check_eq("basic_dv_hold2", led_data_valid, 1);
    check_eq("basic_mcount", meas_count, stat(1));

    // Same-cycle hits, positive result
    do_arm();
    check_eq("rearm_dv_clr", led_data_valid, 0);
    start_hit = 1'b1; start_fine = 8'd50;
    stop_hit  = 1'b1; stop_fine  = 8'd10;
    step();
    start_hit = 1'b0; stop_hit = 1'b0;
    step();
    check_eq("same1_valid", result_valid, 1);
    check_eq("same1_coarse", result_coarse, 0);
    check_eq("same1_ps", result_ps, 1560);
    step();

    // Same-cycle hits, negative result clamps to 0
    do_arm();
    start_hit = 1'b1; start_fine = 8'd10;
    stop_hit  = 1'b1; stop_fine  = 8'd50;
    step();
    start_hit = 1'b0; stop_hit = 1'b0;
    step();
    check_eq("same2_valid", result_valid, 1);
    check_eq("same2_ps", result_ps, 0);
    check_eq("same2_mcount", meas_count, stat(3));
    step();

    // Ignored events: stop in ARMED, second start and arm edge in MEAS
    do_arm();
    stop_hit = 1'b1; stop_fine = 8'd7;
    step();
    stop_hit = 1'b0;
    check_eq("ign_stop_armed", led_measuring, 1);
    step();
    check_eq("ign_stop_novalid", result_valid, 0);
    start_hit = 1'b1; start_fine = 8'd100;
    step();                                  // start edge S
    start_hit = 1'b0;
    repeat (2) step();
    start_hit = 1'b1; start_fine = 8'd255;
    step();                                  // S+3
    start_hit = 1'b0;
    tdc_arm = 1'b1;
    step();                                  // S+4
    tdc_arm = 1'b0;
    check_eq("ign_arm_meas", led_measuring, 1);
    repeat (5) step();                       // S+9
    stop_hit = 1'b1; stop_fine = 8'd60;
    step();                                  // S+10
    stop_hit = 1'b0;
    step();
    check_eq("ign_valid", result_valid, 1);
    check_eq("ign_coarse", result_coarse, 10);
    check_eq("ign_ps", result_ps, 101560);
    step();

    // Timeout
    do_arm();
    start_hit = 1'b1; start_fine = 8'd0;
    step();                                  // start edge S
    start_hit = 1'b0;
    repeat (TimeoutCycles - 1) step();
    check_eq("to_not_yet", led_error, 0);
    step();
    check_eq("to_error", led_error, 1);
    check_eq("to_meas_led", led_measuring, 0);
    check_eq("to_count", timeout_count, stat(1));
    do_arm();
    step();
    check_eq("to_arm_ignored", {led_error, led_measuring}, 2'b10);
    tdc_enable = 1'b0;
    step();
    tdc_enable = 1'b1;
    check_eq("to_clear", {led_error, led_measuring, led_tdc_ready}, 3'b001);
    step();
    do_arm();
    check_eq("to_idle_rearm", led_measuring, 1);

    // Abort mid-measurement
    start_hit = 1'b1; start_fine = 8'd30;
    step();
    start_hit = 1'b0;
    repeat (5) step();
    tdc_enable = 1'b0;
    step();
    check_eq("abort_idle", led_measuring, 0);
    for (int i = 0; i < 3; i++) begin
      check_eq("abort_novalid", result_valid, 0);
      step();
    end
    check_eq("abort_ps_hold", result_ps, 101560);
    check_eq("abort_coarse_hold", result_coarse, 10);
    check_eq("abort_mcount", meas_count, stat(4));
    tdc_enable = 1'b1;
    step();
    do_arm();
    start_hit = 1'b1; start_fine = 8'd0;
    step();
    start_hit = 1'b0;
    repeat (6) step();
    stop_hit = 1'b1; stop_fine = 8'd255;
    step();
    stop_hit = 1'b0;
    step();
    check_eq("post_abort_valid", result_valid, 1);
    check_eq("post_abort_coarse", result_coarse, 7);
    check_eq("post_abort_ps", result_ps, 60055);
    step();
    check_eq("post_abort_mcount", meas_count, stat(5));

    // Asynchronous reset mid-measurement
    do_arm();
    start_hit = 1'b1; start_fine = 8'd1;
    step();
    start_hit = 1'b0;
    repeat (3) step();
    sys_rst_n = 1'b0;
    #1;
    check_eq("arst_leds", {led_tdc_ready, led_measuring, led_data_valid, led_error}, 0);
    check_eq("arst_results", {result_valid, result_coarse, result_ps}, 0);
    check_eq("arst_counts", {meas_count, timeout_count}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
